// File: rtl/phase_scheduler.sv
// Traffic-light phase sequencer with pedestrian service and emergency preemption.
// All outputs are registered; lights are decoded from the next state so they line up with phase.
module phase_scheduler #(
  parameter int FPGAFREQ      = 50_000_000,
  parameter int T_RESET       = 3,
  parameter int T_GREENMAIN   = 18,
  parameter int T_YELLOWMAIN  = 4,
  parameter int T_GREENSEC    = 10,
  parameter int T_YELLOWSEC   = 3,
  parameter int T_GREENPEATON = 5,
  parameter int T_REDPEATON   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ped_req,
  input  logic       emerg_req,
  output logic [2:0] main_lights,
  output logic [2:0] sec_lights,
  output logic [1:0] pea_lights,
  output logic [1:0] ped_pending,
  output logic [2:0] phase,
  output logic [7:0] sec_left
);
  localparam int            CW      = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(FPGAFREQ - 1);

  typedef enum logic [2:0] {
    INIT = 3'd0, MG = 3'd1, MY = 3'd2, SG = 3'd3,
    SY   = 3'd4, PG = 3'd5, PR = 3'd6, EMG = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [7:0]    sec_q, sec_d;
  logic [1:0]    pend_q, pend_d;
  logic [2:0]    main_q, main_d, secl_q, secl_d;
  logic [1:0]    pea_q, pea_d;
  logic          tick, expire;

  function automatic logic [7:0] load_val(input state_e s);
    case (s)
      INIT:    load_val = 8'(T_RESET - 1);
      MG:      load_val = 8'(T_GREENMAIN - 1);
      MY:      load_val = 8'(T_YELLOWMAIN - 1);
      SG:      load_val = 8'(T_GREENSEC - 1);
      SY:      load_val = 8'(T_YELLOWSEC - 1);
      PG:      load_val = 8'(T_GREENPEATON - 1);
      PR:      load_val = 8'(T_REDPEATON - 1);
      default: load_val = 8'd0;
    endcase
  endfunction

  always_comb begin
    tick    = (div_q == DIV_MAX);
    expire  = tick && (sec_q == 8'd0);
    state_d = state_q;
    case (state_q)
      INIT:    if (expire) state_d = emerg_req ? EMG : MG;
      MG:      if (emerg_req || expire) state_d = MY;
      MY:      if (expire) state_d = emerg_req ? EMG : SG;
      SG:      if (emerg_req || expire) state_d = SY;
      SY:      if (expire) state_d = emerg_req ? EMG : ((pend_q != 2'b00) ? PG : MG);
      PG:      if (emerg_req || expire) state_d = PR;
      PR:      if (expire) state_d = emerg_req ? EMG : MG;
      EMG:     if (!emerg_req) state_d = MG;
      default: state_d = INIT;
    endcase

    // A state change restarts both the divider and the seconds countdown.
    if (state_d != state_q) begin
      div_d = '0;
      sec_d = load_val(state_d);
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      sec_d = (tick && sec_q != 8'd0) ? sec_q - 8'd1 : sec_q;
    end

    if (state_d == PG && state_q != PG) pend_d = 2'b00;
    else if (state_q != PG)             pend_d = pend_q | ped_req;
    else                                pend_d = pend_q;

    main_d = (state_d == MG) ? 3'b001 : (state_d == MY) ? 3'b010 : 3'b100;
    secl_d = (state_d == SG) ? 3'b001 : (state_d == SY) ? 3'b010 : 3'b100;
    pea_d  = (state_d == PG) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      div_q   <= '0;
      sec_q   <= 8'(T_RESET - 1);
      pend_q  <= 2'b00;
      main_q  <= 3'b100;
      secl_q  <= 3'b100;
      pea_q   <= 2'b10;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sec_q   <= sec_d;
      pend_q  <= pend_d;
      main_q  <= main_d;
      secl_q  <= secl_d;
      pea_q   <= pea_d;
    end
  end

  assign main_lights = main_q;
  assign sec_lights  = secl_q;
  assign pea_lights  = pea_q;
  assign ped_pending = pend_q;
  assign phase       = state_q;
  assign sec_left    = sec_q;
endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed scenarios plus random traffic against a
// reference model that tracks elapsed cycles per phase.
module tb_phase_scheduler;
  localparam int F = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ped_req = 2'b00;
  logic       emerg_req = 1'b0;
  logic [2:0] main_lights, sec_lights, phase;
  logic [1:0] pea_lights, ped_pending;
  logic [7:0] sec_left;

  phase_scheduler #(
    .FPGAFREQ(F), .T_RESET(2), .T_GREENMAIN(5), .T_YELLOWMAIN(2), .T_GREENSEC(4),
    .T_YELLOWSEC(2), .T_GREENPEATON(3), .T_REDPEATON(2)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .emerg_req(emerg_req),
    .main_lights(main_lights), .sec_lights(sec_lights), .pea_lights(pea_lights),
    .ped_pending(ped_pending), .phase(phase), .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Model: phase code, cycles spent in the phase so far, latched requests.
  int         m_phase = 0;
  int         m_el = 0;
  logic [1:0] m_pend = 2'b00;

  logic [20:0] got;
  assign got = {phase, sec_left, main_lights, sec_lights, pea_lights, ped_pending};

  int         kk = 0;
  logic [2:0] rph [0:255];
  logic [7:0] rsl [0:255];
  logic [1:0] rpd [0:255];
  logic [7:0] rlt [0:255];

  function automatic int dur(input int p);
    case (p)
      0: return 2;  1: return 5;  2: return 2;  3: return 4;
      4: return 2;  5: return 3;  6: return 2;  default: return 1;
    endcase
  endfunction

  function automatic logic [20:0] expv();
    logic [7:0] sl;
    logic [2:0] ml, sc;
    logic [1:0] pl;
    sl = (m_phase == 7) ? 8'd0 : 8'(dur(m_phase) - 1 - m_el / F);
    ml = (m_phase == 1) ? 3'b001 : (m_phase == 2) ? 3'b010 : 3'b100;
    sc = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    pl = (m_phase == 5) ? 2'b01 : 2'b10;
    return {3'(m_phase), sl, ml, sc, pl, m_pend};
  endfunction

  task automatic model(input logic r, input logic [1:0] p, input logic e);
    int nxt;
    bit ex;
    if (r) begin
      m_phase = 0; m_el = 0; m_pend = 2'b00;
      return;
    end
    ex  = (m_phase != 7) && (m_el == dur(m_phase) * F - 1);
    nxt = m_phase;
    case (m_phase)
      1: if (e || ex) nxt = 2;
      3: if (e || ex) nxt = 4;
      5: if (e || ex) nxt = 6;
      7: if (!e) nxt = 1;
      default:
        if (ex) begin
          if (e)                nxt = 7;
          else if (m_phase == 0) nxt = 1;
          else if (m_phase == 2) nxt = 3;
          else if (m_phase == 6) nxt = 1;
          else                   nxt = (m_pend != 2'b00) ? 5 : 1;
        end
    endcase
    if (nxt == 5 && m_phase != 5) m_pend = 2'b00;
    else if (m_phase != 5)        m_pend = m_pend | p;
    m_el    = (nxt != m_phase) ? 0 : m_el + 1;
    m_phase = nxt;
  endtask

  // One clock: drive inputs, advance the model, record what the DUT shows.
  task automatic cyc(input logic r, input logic [1:0] p, input logic e);
    reset = r; ped_req = p; emerg_req = e;
    @(posedge clk);
    model(r, p, e);
    #1;
    kk = r ? 0 : kk + 1;
    if (kk < 256) begin
      rph[kk] = phase; rsl[kk] = sec_left; rpd[kk] = ped_pending;
      rlt[kk] = {main_lights, sec_lights, pea_lights};
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'($urandom_range(3, 0)), 1'b1);
      vectors++;
      if (got !== {3'd0, 8'd1, 3'b100, 3'b100, 2'b10, 2'b00}) begin
        fails++;
        $display("FAIL reset_state got=%h exp=%h", got, {3'd0, 8'd1, 3'b100, 3'b100, 2'b10, 2'b00});
      end
    end
  endtask

  task automatic test_normal_cycle();
    int lk[10] = '{7, 8, 27, 28, 35, 36, 51, 52, 59, 60};
    int lp[10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 1};
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 62; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL normal_cycle k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rph[lk[i]] !== 3'(lp[i])) begin
        fails++; $display("FAIL normal_phase k=%0d got=%0d exp=%0d", lk[i], rph[lk[i]], lp[i]);
      end
    end
    vectors++;
    if (rsl[60] !== 8'd4) begin
      fails++; $display("FAIL normal_mg_reload got=%0d exp=4", rsl[60]);
    end
  endtask

  task automatic test_ped_single();
    int lk[6] = '{59, 60, 71, 72, 79, 80};
    int lp[6] = '{4, 5, 5, 6, 6, 1};
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 82; k++) begin
      cyc(1'b0, (k == 37) ? 2'b01 : 2'b00, 1'b0);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL ped_single k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rph[lk[i]] !== 3'(lp[i])) begin
        fails++; $display("FAIL ped_single_phase k=%0d got=%0d exp=%0d", lk[i], rph[lk[i]], lp[i]);
      end
    end
    vectors++;
    if (rpd[37] !== 2'b01 || rpd[60] !== 2'b00 || rlt[60][1:0] !== 2'b01) begin
      fails++;
      $display("FAIL ped_single_latch got=%b/%b/%b exp=01/00/01", rpd[37], rpd[60], rlt[60][1:0]);
    end
  endtask

  task automatic test_ped_both();
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 135; k++) begin
      cyc(1'b0, (k == 10 || k == 65) ? 2'b11 : 2'b00, 1'b0);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL ped_both k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    vectors++;
    if (rpd[10] !== 2'b11 || rph[60] !== 3'd5 || rpd[66] !== 2'b00 || rph[72] !== 3'd6 || rpd[72] !== 2'b00) begin
      fails++;
      $display("FAIL ped_both_serve got=%b,%0d,%b,%0d,%b exp=11,5,00,6,00",
               rpd[10], rph[60], rpd[66], rph[72], rpd[72]);
    end
    vectors++;
    if (rph[131] !== 3'd4 || rph[132] !== 3'd1 || rpd[132] !== 2'b00) begin
      fails++;
      $display("FAIL ped_both_next_sy got=%0d,%0d,%b exp=4,1,00", rph[131], rph[132], rpd[132]);
    end
  endtask

  task automatic test_emerg_mg();
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 35; k++) begin
      cyc(1'b0, 2'b00, (k >= 15 && k <= 30));
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL emerg_mg k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    vectors++;
    if (rph[14] !== 3'd1 || rph[15] !== 3'd2 || rsl[15] !== 8'd1 || rph[22] !== 3'd2) begin
      fails++;
      $display("FAIL emerg_preempt got=%0d,%0d,%0d,%0d exp=1,2,1,2", rph[14], rph[15], rsl[15], rph[22]);
    end
    vectors++;
    if (rph[23] !== 3'd7 || rsl[23] !== 8'd0 || rlt[23] !== 8'b100_100_10 || rph[30] !== 3'd7) begin
      fails++;
      $display("FAIL emerg_hold got=%0d,%0d,%b,%0d exp=7,0,10010010,7", rph[23], rsl[23], rlt[23], rph[30]);
    end
    vectors++;
    if (rph[31] !== 3'd1 || rsl[31] !== 8'd4) begin
      fails++; $display("FAIL emerg_release got=%0d,%0d exp=1,4", rph[31], rsl[31]);
    end
  endtask

  task automatic test_emerg_sy_pending();
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      cyc(1'b0, (k == 40) ? 2'b10 : 2'b00, (k >= 55 && k <= 65));
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL emerg_sy k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    vectors++;
    if (rph[60] !== 3'd7 || rpd[60] !== 2'b10 || rpd[65] !== 2'b10 || rph[66] !== 3'd1 || rpd[66] !== 2'b10) begin
      fails++;
      $display("FAIL emerg_sy_priority got=%0d,%b,%b,%0d,%b exp=7,10,10,1,10",
               rph[60], rpd[60], rpd[65], rph[66], rpd[66]);
    end
    vectors++;
    if (rph[117] !== 3'd4 || rph[118] !== 3'd5 || rpd[118] !== 2'b00) begin
      fails++;
      $display("FAIL emerg_sy_later_pg got=%0d,%0d,%b exp=4,5,00", rph[117], rph[118], rpd[118]);
    end
  endtask

  task automatic test_reset_mid_pg();
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 63; k++) begin
      cyc(1'b0, (k == 40) ? 2'b01 : 2'b00, 1'b0);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL reset_pg k=%0d got=%h exp=%h", k, got, expv());
      end
    end
    vectors++;
    if (phase !== 3'd5) begin
      fails++; $display("FAIL reset_pg_setup got=%0d exp=5", phase);
    end
    cyc(1'b1, 2'b11, 1'b1);
    vectors++;
    if (got !== {3'd0, 8'd1, 3'b100, 3'b100, 2'b10, 2'b00}) begin
      fails++; $display("FAIL reset_pg_forced got=%h exp=%h", got, {3'd0, 8'd1, 3'b100, 3'b100, 2'b10, 2'b00});
    end
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 2'b00, 1'b0);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL reset_pg_after k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  task automatic test_random();
    logic e = 1'b0;
    logic [1:0] p;
    cyc(1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(29, 0) == 0) e = ~e;
      p = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
      cyc(($urandom_range(99, 0) == 0), p, e);
      vectors++;
      if (got !== expv()) begin
        fails++; $display("FAIL random k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_single();
    test_ped_both();
    test_emerg_mg();
    test_emerg_sy_pending();
    test_reset_mid_pg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
